i2si_bist_chk: RTL and testbench

I2SI_BIST_CHK -- requirements
Module: i2si_bist_chk

---
 rtl/i2si_bist_chk.sv | 238 +++++++++++++++++++++++
 tb/tb_i2si_bist_chk.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2si_bist_chk.sv
// ----------------------------------------------------------------------------
// i2si_bist_chk
//
// Purpose:
//   Built-in self-test checker for the I2S input path. It watches valid
//   stereo sample words and compares them against a programmable
//   ramp sequence (start, increment, upper limit with wrap to start).
//   It first seeks the start value, then requires LOCK_CNT consecutive
//   matching words before it declares lock. Once locked, it counts every
//   checked word and every mismatch, and keeps a sticky error flag.
//
// Parameters:
//   ERR_CNT_W : width of the error and word counters (both saturate)
//   LOCK_CNT  : consecutive matching words needed to enter CHECK
//
// Ports:
//   clk                 i  system clock, rising edge
//   rst                 i  asynchronous reset, active low
//   rf_bist_chk_en      i  checker enable (level); low forces IDLE
//   rf_bist_start_val   i  first value of the sequence and wrap target
//   rf_bist_inc         i  sequence increment
//   rf_bist_up_limit    i  sequence upper limit (inclusive)
//   rf_bist_err_clr     i  pulse: clear error count, word count, sticky err
//   i2si_bist_in_data   i  sample word {left[15:0], right[15:0]}
//   i2si_bist_in_valid  i  qualifies i2si_bist_in_data
//   i2si_bist_locked    o  high while in CHECK
//   i2si_bist_err       o  sticky mismatch flag
//   i2si_bist_err_cnt   o  saturating mismatch count
//   i2si_bist_word_cnt  o  saturating count of words checked in CHECK
// ----------------------------------------------------------------------------
module i2si_bist_chk #(
   parameter int ERR_CNT_W = 16,
   parameter int LOCK_CNT  = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rf_bist_chk_en,
   input  logic [11:0]          rf_bist_start_val,
   input  logic [7:0]           rf_bist_inc,
   input  logic [11:0]          rf_bist_up_limit,
   input  logic                 rf_bist_err_clr,
   input  logic [31:0]          i2si_bist_in_data,
   input  logic                 i2si_bist_in_valid,
   output logic                 i2si_bist_locked,
   output logic                 i2si_bist_err,
   output logic [ERR_CNT_W-1:0] i2si_bist_err_cnt,
   output logic [ERR_CNT_W-1:0] i2si_bist_word_cnt
);

   localparam int MC_W = $clog2(LOCK_CNT + 1);
   localparam logic [MC_W-1:0] LOCK_VAL = MC_W'(LOCK_CNT);
   localparam logic [ERR_CNT_W-1:0] CNT_ONE = ERR_CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SEEK  = 2'd1,
      ST_LOCK  = 2'd2,
      ST_CHECK = 2'd3
   } state_t;

   // Next sequence value: 13-bit sum so an overflow past 12 bits is still
   // seen as exceeding the limit and wraps to the start value.
   function automatic logic [11:0] f_next_val(
      input logic [11:0] cur,
      input logic [7:0]  inc,
      input logic [11:0] limit,
      input logic [11:0] start
   );
      logic [12:0] sum;
      sum = {1'b0, cur} + {5'b0, inc};
      if (sum > {1'b0, limit}) begin
         return start;
      end
      return sum[11:0];
   endfunction

   // ------------------------------------------------------------------------
   // Registered state
   // ------------------------------------------------------------------------
   state_t                r_state;
   logic [11:0]           r_exp;
   logic [MC_W-1:0]       r_match_cnt;
   logic                  r_locked;
   logic                  r_err;
   logic [ERR_CNT_W-1:0]  r_err_cnt;
   logic [ERR_CNT_W-1:0]  r_word_cnt;

   // ------------------------------------------------------------------------
   // Combinational next values
   // ------------------------------------------------------------------------
   state_t                w_state_nxt;
   logic [11:0]           w_exp_nxt;
   logic [MC_W-1:0]       w_match_cnt_nxt;
   logic                  w_err_nxt;
   logic [ERR_CNT_W-1:0]  w_err_cnt_nxt;
   logic [ERR_CNT_W-1:0]  w_word_cnt_nxt;

   logic [15:0]           w_ch_l;
   logic [15:0]           w_ch_r;
   logic                  w_match_exp;
   logic                  w_match_start;
   logic [11:0]           w_exp_adv;
   logic [11:0]           w_start_adv;
   logic [MC_W-1:0]       w_match_cnt_inc;
   logic                  w_entry_clr;
   logic                  w_word_evt;
   logic                  w_err_evt;

   assign w_ch_l = i2si_bist_in_data[31:16];
   assign w_ch_r = i2si_bist_in_data[15:0];

   // Both channels must carry the value with a zero pad nibble; any pad bit
   // or a left/right disagreement therefore fails the compare.
   assign w_match_exp   = (w_ch_l == {4'h0, r_exp}) &&
                          (w_ch_r == {4'h0, r_exp});
   assign w_match_start = (w_ch_l == {4'h0, rf_bist_start_val}) &&
                          (w_ch_r == {4'h0, rf_bist_start_val});

   assign w_exp_adv   = f_next_val(r_exp, rf_bist_inc, rf_bist_up_limit,
                                   rf_bist_start_val);
   assign w_start_adv = f_next_val(rf_bist_start_val, rf_bist_inc,
                                   rf_bist_up_limit, rf_bist_start_val);
   assign w_match_cnt_inc = r_match_cnt + MC_W'(1);

   // NOTE: every signal assigned in this block gets a default first, so no
   // path leaves one unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt     = r_state;
      w_exp_nxt       = r_exp;
      w_match_cnt_nxt = r_match_cnt;
      w_err_nxt       = r_err;
      w_err_cnt_nxt   = r_err_cnt;
      w_word_cnt_nxt  = r_word_cnt;
      w_entry_clr     = 1'b0;
      w_word_evt      = 1'b0;
      w_err_evt       = 1'b0;

      if (!rf_bist_chk_en) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_state_nxt     = ST_SEEK;
               w_match_cnt_nxt = '0;
               w_entry_clr     = 1'b1;
            end

            ST_SEEK: begin
               if (i2si_bist_in_valid && w_match_start) begin
                  w_exp_nxt       = w_start_adv;
                  w_match_cnt_nxt = MC_W'(1);
                  w_state_nxt     = (LOCK_CNT == 1) ? ST_CHECK : ST_LOCK;
               end
            end

            ST_LOCK: begin
               if (i2si_bist_in_valid) begin
                  if (w_match_exp) begin
                     w_exp_nxt       = w_exp_adv;
                     w_match_cnt_nxt = w_match_cnt_inc;
                     if (w_match_cnt_inc == LOCK_VAL) begin
                        w_state_nxt = ST_CHECK;
                     end
                  end else begin
                     // Lost sync before lock: look for the start value again.
                     w_match_cnt_nxt = '0;
                     w_state_nxt     = ST_SEEK;
                  end
               end
            end

            ST_CHECK: begin
               if (i2si_bist_in_valid) begin
                  // Advance from the expected value even on a mismatch so one
                  // corrupted word costs exactly one error.
                  w_exp_nxt  = w_exp_adv;
                  w_word_evt = 1'b1;
                  w_err_evt  = !w_match_exp;
               end
            end

            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end

      // Counter and sticky-flag update. A clear that coincides with a counted
      // event leaves the counter at 1 rather than 0.
      if (w_entry_clr) begin
         w_err_nxt      = 1'b0;
         w_err_cnt_nxt  = '0;
         w_word_cnt_nxt = '0;
      end else if (rf_bist_err_clr) begin
         w_err_nxt      = w_err_evt;
         w_err_cnt_nxt  = w_err_evt  ? CNT_ONE : '0;
         w_word_cnt_nxt = w_word_evt ? CNT_ONE : '0;
      end else begin
         if (w_err_evt) begin
            w_err_nxt = 1'b1;
            if (r_err_cnt != '1) begin
               w_err_cnt_nxt = r_err_cnt + CNT_ONE;
            end
         end
         if (w_word_evt && (r_word_cnt != '1)) begin
            w_word_cnt_nxt = r_word_cnt + CNT_ONE;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_exp       <= '0;
         r_match_cnt <= '0;
         r_locked    <= 1'b0;
         r_err       <= 1'b0;
         r_err_cnt   <= '0;
         r_word_cnt  <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_exp       <= w_exp_nxt;
         r_match_cnt <= w_match_cnt_nxt;
         r_locked    <= (w_state_nxt == ST_CHECK);
         r_err       <= w_err_nxt;
         r_err_cnt   <= w_err_cnt_nxt;
         r_word_cnt  <= w_word_cnt_nxt;
      end
   end

   assign i2si_bist_locked   = r_locked;
   assign i2si_bist_err      = r_err;
   assign i2si_bist_err_cnt  = r_err_cnt;
   assign i2si_bist_word_cnt = r_word_cnt;

endmodule

// File: tb/tb_i2si_bist_chk.sv
// ----------------------------------------------------------------------------
// tb_i2si_bist_chk
//
// Directed bench for i2si_bist_chk. Two instances share all stimulus: one
// with default parameters and one with ERR_CNT_W=4 for counter saturation.
// Inputs change on the falling edge; outputs are compared on the following
// falling edge, i.e. one cycle after a word is presented.
// ----------------------------------------------------------------------------
module tb_i2si_bist_chk;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [11:0] start_val;
   logic [7:0]  inc;
   logic [11:0] up_limit;
   logic        err_clr;
   logic [31:0] in_data;
   logic        in_valid;

   logic        locked;
   logic        err;
   logic [15:0] err_cnt;
   logic [15:0] word_cnt;

   logic        locked4;
   logic        err4;
   logic [3:0]  err_cnt4;
   logic [3:0]  word_cnt4;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   i2si_bist_chk dut (
      .clk                (clk),
      .rst                (rst),
      .rf_bist_chk_en     (en),
      .rf_bist_start_val  (start_val),
      .rf_bist_inc        (inc),
      .rf_bist_up_limit   (up_limit),
      .rf_bist_err_clr    (err_clr),
      .i2si_bist_in_data  (in_data),
      .i2si_bist_in_valid (in_valid),
      .i2si_bist_locked   (locked),
      .i2si_bist_err      (err),
      .i2si_bist_err_cnt  (err_cnt),
      .i2si_bist_word_cnt (word_cnt)
   );

   i2si_bist_chk #(.ERR_CNT_W(4)) dut_w4 (
      .clk                (clk),
      .rst                (rst),
      .rf_bist_chk_en     (en),
      .rf_bist_start_val  (start_val),
      .rf_bist_inc        (inc),
      .rf_bist_up_limit   (up_limit),
      .rf_bist_err_clr    (err_clr),
      .i2si_bist_in_data  (in_data),
      .i2si_bist_in_valid (in_valid),
      .i2si_bist_locked   (locked4),
      .i2si_bist_err      (err4),
      .i2si_bist_err_cnt  (err_cnt4),
      .i2si_bist_word_cnt (word_cnt4)
   );

   function automatic logic [31:0] wd(input logic [11:0] v);
      return {4'h0, v, 4'h0, v};
   endfunction

   // Present one valid word; returns on the next falling edge.
   task automatic send(input logic [31:0] d);
      in_data  = d;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic enable_chk();
      start_val = 12'h001;
      inc       = 8'h01;
      up_limit  = 12'h019;
      en        = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b0; en = 1'b0; err_clr = 1'b0; in_valid = 1'b0; in_data = '0;
      start_val = '0; inc = '0; up_limit = '0;
      repeat (2) @(negedge clk);
      n_total++;
      if ({locked, err, err_cnt, word_cnt} !== 34'd0) begin
         $display("FAIL reset_outputs: got %h, want 0", {locked, err, err_cnt, word_cnt});
      end else n_pass++;
      n_total++;
      if ({locked4, err4, err_cnt4, word_cnt4} !== 10'd0) begin
         $display("FAIL reset_outputs_w4: got %h, want 0", {locked4, err4, err_cnt4, word_cnt4});
      end else n_pass++;
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_lock();
      enable_chk();
      send(wd(12'h001));
      send(wd(12'h002));
      send(wd(12'h003));
      n_total++;
      if (locked !== 1'b0) $display("FAIL lock_early: locked=%b, want 0", locked);
      else n_pass++;
      send(wd(12'h004));
      n_total++;
      if (locked !== 1'b1) $display("FAIL lock_4th: locked=%b, want 1", locked);
      else n_pass++;
      n_total++;
      if ({err, err_cnt, word_cnt} !== 33'd0) begin
         $display("FAIL lock_counts: err=%b err_cnt=%0d word_cnt=%0d, want 0/0/0", err, err_cnt, word_cnt);
      end else n_pass++;
   endtask

   task automatic test_wrap();
      for (int v = 5; v <= 25; v++) send(wd(12'(v)));
      send(wd(12'h001));
      send(wd(12'h002));
      n_total++;
      if (word_cnt !== 16'd23) $display("FAIL wrap_word_cnt: got %0d, want 23", word_cnt);
      else n_pass++;
      n_total++;
      if ({err, err_cnt} !== 17'd0) $display("FAIL wrap_no_err: err=%b err_cnt=%0d, want 0/0", err, err_cnt);
      else n_pass++;
      // Invalid cycles carrying the expected word must be ignored.
      in_data = wd(12'h003);
      repeat (3) @(negedge clk);
      n_total++;
      if (word_cnt !== 16'd23) $display("FAIL invalid_ignored: word_cnt=%0d, want 23", word_cnt);
      else n_pass++;
   endtask

   task automatic test_single_error();
      send(wd(12'h003));
      send(wd(12'h004));
      send(32'h0007_0008);
      n_total++;
      if ({locked, err, err_cnt} !== {1'b1, 1'b1, 16'd1}) begin
         $display("FAIL single_err: locked=%b err=%b err_cnt=%0d, want 1/1/1", locked, err, err_cnt);
      end else n_pass++;
      send(wd(12'h006));
      send(wd(12'h007));
      send(wd(12'h008));
      n_total++;
      if ({err_cnt, word_cnt} !== {16'd1, 16'd29}) begin
         $display("FAIL single_err_resume: err_cnt=%0d word_cnt=%0d, want 1/29", err_cnt, word_cnt);
      end else n_pass++;
   endtask

   task automatic test_pad();
      // Right value, nonzero pad nibble on the left channel.
      send(32'h1009_0009);
      n_total++;
      if (err_cnt !== 16'd2) $display("FAIL pad_nibble: err_cnt=%0d, want 2", err_cnt);
      else n_pass++;
   endtask

   task automatic test_saturation();
      repeat (20) send(32'hFFFF_FFFF);
      n_total++;
      if (err_cnt4 !== 4'hF) $display("FAIL sat_w4: err_cnt=%h, want f", err_cnt4);
      else n_pass++;
      n_total++;
      if ({err_cnt, word_cnt} !== {16'd22, 16'd50}) begin
         $display("FAIL sat_w16: err_cnt=%0d word_cnt=%0d, want 22/50", err_cnt, word_cnt);
      end else n_pass++;
      err_clr = 1'b1;
      send(32'hFFFF_FFFF);
      err_clr = 1'b0;
      n_total++;
      if ({err4, err_cnt4} !== {1'b1, 4'h1}) begin
         $display("FAIL clr_with_err_w4: err=%b err_cnt=%h, want 1/1", err4, err_cnt4);
      end else n_pass++;
      n_total++;
      if ({err, err_cnt, word_cnt} !== {1'b1, 16'd1, 16'd1}) begin
         $display("FAIL clr_with_err: err=%b err_cnt=%0d word_cnt=%0d, want 1/1/1", err, err_cnt, word_cnt);
      end else n_pass++;
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      n_total++;
      if ({err, err_cnt, word_cnt} !== 33'd0) begin
         $display("FAIL clr_only: err=%b err_cnt=%0d word_cnt=%0d, want 0/0/0", err, err_cnt, word_cnt);
      end else n_pass++;
      // Expected value kept advancing through the mismatches: 5 then 6.
      send(wd(12'h006));
      n_total++;
      if ({err_cnt, word_cnt} !== {16'd0, 16'd1}) begin
         $display("FAIL resync_after_err: err_cnt=%0d word_cnt=%0d, want 0/1", err_cnt, word_cnt);
      end else n_pass++;
   endtask

   task automatic test_enable_drop();
      en = 1'b0;
      @(negedge clk);
      n_total++;
      if ({locked, word_cnt} !== {1'b0, 16'd1}) begin
         $display("FAIL en_drop: locked=%b word_cnt=%0d, want 0/1", locked, word_cnt);
      end else n_pass++;
      send(wd(12'h007));
      n_total++;
      if ({locked, word_cnt} !== {1'b0, 16'd1}) begin
         $display("FAIL idle_hold: locked=%b word_cnt=%0d, want 0/1", locked, word_cnt);
      end else n_pass++;
   endtask

   task automatic test_lock_fail();
      enable_chk();
      n_total++;
      if (word_cnt !== 16'd0) $display("FAIL enable_clears: word_cnt=%0d, want 0", word_cnt);
      else n_pass++;
      send(wd(12'h001));
      send(wd(12'h002));
      send(wd(12'h009));
      n_total++;
      if ({locked, err, err_cnt} !== 18'd0) begin
         $display("FAIL lock_fail: locked=%b err=%b err_cnt=%0d, want 0/0/0", locked, err, err_cnt);
      end else n_pass++;
      send(wd(12'h001));
      send(wd(12'h002));
      send(wd(12'h003));
      n_total++;
      if (locked !== 1'b0) $display("FAIL relock_early: locked=%b, want 0", locked);
      else n_pass++;
      send(wd(12'h004));
      n_total++;
      if (locked !== 1'b1) $display("FAIL relock: locked=%b, want 1", locked);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      send(wd(12'h005));
      send(32'h00FF_00FF);
      n_total++;
      if ({locked, err, err_cnt, word_cnt} !== {1'b1, 1'b1, 16'd1, 16'd2}) begin
         $display("FAIL pre_reset: locked=%b err=%b err_cnt=%0d word_cnt=%0d, want 1/1/1/2", locked, err, err_cnt, word_cnt);
      end else n_pass++;
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      n_total++;
      if ({locked, err, err_cnt, word_cnt} !== 34'd0) begin
         $display("FAIL async_reset: got %h, want 0", {locked, err, err_cnt, word_cnt});
      end else n_pass++;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      send(wd(12'h001));
      send(wd(12'h002));
      send(wd(12'h003));
      send(wd(12'h004));
      n_total++;
      if ({locked, err_cnt} !== {1'b1, 16'd0}) begin
         $display("FAIL relock_after_reset: locked=%b err_cnt=%0d, want 1/0", locked, err_cnt);
      end else n_pass++;
   endtask

   initial begin
      test_reset();
      test_lock();
      test_wrap();
      test_single_error();
      test_pad();
      test_saturation();
      test_enable_drop();
      test_lock_fail();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
